// File: rtl/pulse_seq_engine_if.sv
// rtl/pulse_seq_engine_if.sv - host configuration port of the pulse sequence engine
//
// Purpose: groups the edge-table write path, the bank-swap request and its
// acknowledge into one bundle shared by the host (master) and the engine (slave).
//
// Signals:
//   cfg_we    host -> engine  write cfg_data into the shadow bank at cfg_addr
//   cfg_addr  host -> engine  shadow-table entry index
//   cfg_data  host -> engine  entry {en, ch, dx, x}
//   cfg_swap  host -> engine  request shadow<->active bank swap
//   swap_ack  engine -> host  one-cycle pulse on the cycle the active bank flips
interface pulse_seq_engine_if #(
    parameter int COUNT_BITS = 32,
    parameter int CH_LOG2    = 3,
    parameter int ED_LOG2    = 4
);
    localparam int ED_BITS = 1 + CH_LOG2 + 2 * COUNT_BITS;

    logic               cfg_we;
    logic [ED_LOG2-1:0] cfg_addr;
    logic [ED_BITS-1:0] cfg_data;
    logic               cfg_swap;
    logic               swap_ack;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        output cfg_swap,
        input  swap_ack
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_swap,
        output swap_ack
    );
endinterface

// File: rtl/pulse_seq_engine.sv
// rtl/pulse_seq_engine.sv - N-channel pulse waveform generator with double-buffered edge table
//
// Purpose: plays a table of edges onto CH_MAX channel outputs. Each entry toggles
// one channel once the inner counter reaches its effective edge time; the edge
// time moves by dx every inner period and reloads from x every outer period.
// The host fills the shadow bank while the active bank plays and swaps banks at
// an outer-period boundary (or at once when not running).
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       synchronous reset, active-low
//   cfg           configuration bundle (slave side): table writes, swap request/ack
//   period        signed inner period in clocks (<=0 acts as 1)
//   outer_period  signed outer period in inner periods (<=0 acts as 1)
//   state0        idle/initial level per channel
//   mode          00 continuous, 01 one-shot, 10 triggered one-shot, 11 continuous
//   start         start (modes 00/01) or arm (mode 10) from IDLE
//   stop          abort to IDLE, wins over start/trig
//   trig          trigger, level-sampled in ARMED
//   state         registered channel outputs
//   running       high while in RUN
//   done          one-cycle pulse at the natural end of a one-shot
module pulse_seq_engine #(
    parameter int COUNT_BITS = 32,
    parameter int CH_LOG2    = 3,
    parameter int ED_LOG2    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    pulse_seq_engine_if.slave            cfg,
    input  logic signed [COUNT_BITS-1:0] period,
    input  logic signed [COUNT_BITS-1:0] outer_period,
    input  logic [(1<<CH_LOG2)-1:0]      state0,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         trig,
    output logic [(1<<CH_LOG2)-1:0]      state,
    output logic                         running,
    output logic                         done
);
    localparam int CH_MAX  = 1 << CH_LOG2;
    localparam int ED_MAX  = 1 << ED_LOG2;
    localparam int ED_BITS = 1 + CH_LOG2 + 2 * COUNT_BITS;
    localparam int EW      = COUNT_BITS + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_TRIG    = 2'b10;

    // bank_q[b][i]: entry i of bank b; active_q selects the playing bank.
    logic [ED_BITS-1:0]           bank_q [2][ED_MAX];
    logic                         active_q;
    logic                         pending_q;
    logic                         swap_ack_q;
    logic                         done_q, done_d;
    logic [1:0]                   fsm_q, fsm_d;
    logic [1:0]                   mode_q, mode_d;
    logic signed [COUNT_BITS-1:0] count_q, count_d;
    logic signed [COUNT_BITS-1:0] outer_q, outer_d;
    logic signed [EW-1:0]         eff_q [ED_MAX];
    logic signed [EW-1:0]         eff_d [ED_MAX];
    logic [CH_MAX-1:0]            state_q, state_d;
    logic [CH_MAX-1:0]            tog;

    logic signed [COUNT_BITS-1:0] p_eff, op_eff;
    logic                         in_run;
    logic                         inner_wrap, outer_wrap;
    logic                         do_swap;
    logic                         src_bank;
    logic                         run_entry, run_stay;

    assign p_eff  = (period > 0)       ? period       : COUNT_BITS'(1);
    assign op_eff = (outer_period > 0) ? outer_period : COUNT_BITS'(1);

    assign in_run     = (fsm_q == ST_RUN);
    assign inner_wrap = in_run && (count_q == p_eff - COUNT_BITS'(1));
    assign outer_wrap = inner_wrap && (outer_q == op_eff - COUNT_BITS'(1));

    // A request arriving in the same cycle as its landing slot is honoured
    // without waiting for a further boundary.
    assign do_swap  = (pending_q | cfg.cfg_swap) & (~in_run | outer_wrap);
    // Bank that eff[] loads from: the one that is active after this edge.
    assign src_bank = active_q ^ do_swap;

    always_comb begin
        fsm_d  = fsm_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (stop) begin
            fsm_d = ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d = mode;
                        fsm_d  = (mode == MODE_TRIG) ? ST_ARMED : ST_RUN;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        fsm_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (outer_wrap && mode_q == MODE_ONESHOT) begin
                        fsm_d  = ST_IDLE;
                        done_d = 1'b1;
                    end else if (outer_wrap && mode_q == MODE_TRIG) begin
                        fsm_d  = ST_ARMED;
                        done_d = 1'b1;
                    end
                end
                default: fsm_d = ST_IDLE;
            endcase
        end
    end

    assign run_entry = !in_run && (fsm_d == ST_RUN);
    assign run_stay  = in_run && (fsm_d == ST_RUN);

    // Counters only advance while RUN continues; any other path parks them at 0
    // so the next RUN entry starts from count=outer=0.
    always_comb begin
        count_d = '0;
        outer_d = '0;
        if (run_stay) begin
            if (inner_wrap) begin
                count_d = '0;
                outer_d = outer_wrap ? '0 : outer_q + COUNT_BITS'(1);
            end else begin
                count_d = count_q + COUNT_BITS'(1);
                outer_d = outer_q;
            end
        end
    end

    always_comb begin
        logic [ED_BITS-1:0]    ent;
        logic [COUNT_BITS-1:0] ex;
        logic [COUNT_BITS-1:0] edx;
        ent = '0;
        ex  = '0;
        edx = '0;
        for (int i = 0; i < ED_MAX; i++) begin
            ent      = bank_q[src_bank][i];
            ex       = ent[COUNT_BITS-1:0];
            edx      = ent[2*COUNT_BITS-1:COUNT_BITS];
            eff_d[i] = eff_q[i];
            if (run_entry || (run_stay && outer_wrap)) begin
                eff_d[i] = $signed({ex[COUNT_BITS-1], ex});
            end else if (run_stay && inner_wrap) begin
                eff_d[i] = eff_q[i] + $signed({edx[COUNT_BITS-1], edx});
            end
        end
    end

    // Several entries may target one channel; their hits combine by XOR.
    always_comb begin
        logic [ED_BITS-1:0] act;
        logic [CH_LOG2-1:0] ch;
        act = '0;
        ch  = '0;
        tog = '0;
        for (int i = 0; i < ED_MAX; i++) begin
            act = bank_q[active_q][i];
            ch  = act[ED_BITS-2 -: CH_LOG2];
            if (act[ED_BITS-1] && ($signed(count_q) >= eff_q[i])) begin
                tog[ch] = ~tog[ch];
            end
        end
    end

    assign state_d = in_run ? (state0 ^ tog) : state0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ED_MAX; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            for (int i = 0; i < ED_MAX; i++) begin
                eff_q[i] <= '0;
            end
            active_q   <= 1'b0;
            pending_q  <= 1'b0;
            swap_ack_q <= 1'b0;
            done_q     <= 1'b0;
            fsm_q      <= ST_IDLE;
            mode_q     <= 2'b00;
            count_q    <= '0;
            outer_q    <= '0;
            state_q    <= '0;
        end else begin
            // Writes target the pre-swap shadow bank, so data written on a swap
            // cycle lands in the bank that becomes active.
            if (cfg.cfg_we) begin
                bank_q[~active_q][cfg.cfg_addr] <= cfg.cfg_data;
            end
            for (int i = 0; i < ED_MAX; i++) begin
                eff_q[i] <= eff_d[i];
            end
            active_q   <= active_q ^ do_swap;
            pending_q  <= (pending_q | cfg.cfg_swap) & ~do_swap;
            swap_ack_q <= do_swap;
            done_q     <= done_d;
            fsm_q      <= fsm_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            outer_q    <= outer_d;
            state_q    <= state_d;
        end
    end

    assign state        = state_q;
    assign running      = in_run;
    assign done         = done_q;
    assign cfg.swap_ack = swap_ack_q;

endmodule

// File: tb/tb_pulse_seq_engine.sv
// tb/tb_pulse_seq_engine.sv - scoreboard testbench for pulse_seq_engine
module tb_pulse_seq_engine;
    logic               clk;
    logic               reset_n;
    logic signed [31:0] period;
    logic signed [31:0] outer_period;
    logic [7:0]         state0;
    logic [1:0]         mode;
    logic               start;
    logic               stop;
    logic               trig;
    logic [7:0]         state;
    logic               running;
    logic               done;

    int checks   = 0;
    int failures = 0;

    pulse_seq_engine_if cfg_if ();

    pulse_seq_engine dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg          (cfg_if),
        .period       (period),
        .outer_period (outer_period),
        .state0       (state0),
        .mode         (mode),
        .start        (start),
        .stop         (stop),
        .trig         (trig),
        .state        (state),
        .running      (running),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] st;
        logic [7:0] mask;
        logic       run;
        logic       dn;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: one expected record per observed cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ((state & e.mask) !== (e.st & e.mask)) begin
                failures++;
                $display("FAIL %s state got=%h exp=%h mask=%h", e.name, state, e.st, e.mask);
            end
            checks++;
            if (running !== e.run) begin
                failures++;
                $display("FAIL %s running got=%b exp=%b", e.name, running, e.run);
            end
            checks++;
            if (done !== e.dn) begin
                failures++;
                $display("FAIL %s done got=%b exp=%b", e.name, done, e.dn);
            end
            checks++;
            if (cfg_if.swap_ack !== e.ack) begin
                failures++;
                $display("FAIL %s swap_ack got=%b exp=%b", e.name, cfg_if.swap_ack, e.ack);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] st, input logic [7:0] m,
                              input logic r, input logic d, input logic a);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.mask = m;
        e.run  = r;
        e.dn   = d;
        e.ack  = a;
        sb_q.push_back(e);
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic en, input logic [2:0] ch,
                               input logic [31:0] dx, input logic [31:0] x);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_addr = addr;
        cfg_if.cfg_data = {en, ch, dx, x};
        tick();
        cfg_if.cfg_we   = 1'b0;
    endtask

    task automatic swap_idle(input string nm);
        cfg_if.cfg_swap = 1'b1;
        tick();
        cfg_if.cfg_swap = 1'b0;
        expect_out(nm, state0, 8'hFF, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic stop_run(input string nm);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out(nm, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out(nm, state0, 8'hFF, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        failures++;
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int o;
        logic [7:0] st;

        reset_n         = 1'b0;
        period          = 32'sd1;
        outer_period    = 32'sd1;
        state0          = 8'hA5;
        mode            = 2'b00;
        start           = 1'b0;
        stop            = 1'b0;
        trig            = 1'b0;
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_addr = '0;
        cfg_if.cfg_data = '0;
        cfg_if.cfg_swap = 1'b0;

        // 1 reset, then IDLE follows state0
        tick();
        expect_out("reset0", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("reset1", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        expect_out("idle_state0", 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0);

        // 2 continuous: ch2 edge at x=3, P=10, OP=1
        state0 = 8'h00;
        write_entry(4'd0, 1'b1, 3'd2, 32'd0, 32'd3);
        swap_idle("swap_idle_a");
        period       = 32'sd10;
        outer_period = 32'sd1;
        mode         = 2'b00;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("cont_k0", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            st = (((k - 1) % 10) >= 3) ? 8'h04 : 8'h00;
            expect_out($sformatf("cont_k%0d", k), st, 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        stop_run("cont_stop");

        // 3 sweep: ch5 x=2 dx=1, P=8, OP=3
        write_entry(4'd0, 1'b1, 3'd5, 32'd1, 32'd2);
        swap_idle("swap_idle_b");
        period       = 32'sd8;
        outer_period = 32'sd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("sweep_k0", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            c  = (k - 1) % 8;
            o  = ((k - 1) / 8) % 3;
            st = (c >= 2 + o) ? 8'h20 : 8'h00;
            expect_out($sformatf("sweep_k%0d", k), st, 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        stop_run("sweep_stop");

        // 4 one-shot: P=5, OP=2, same table; start mid-run ignored
        state0       = 8'h11;
        mode         = 2'b01;
        period       = 32'sd5;
        outer_period = 32'sd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("oneshot_k0", 8'h11, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            start = (k == 3);
            tick();
            c  = (k - 1) % 5;
            o  = (k - 1) / 5;
            st = 8'h11 ^ ((c >= 2 + o) ? 8'h20 : 8'h00);
            expect_out($sformatf("oneshot_k%0d", k), st, 8'hFF, (k <= 9), (k == 10), 1'b0);
        end
        start = 1'b0;
        tick();
        expect_out("oneshot_end", 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0);

        // 5 swap mid-run: ch1 x=3 active, shadow x=6, swap requested at outer=0
        state0 = 8'h00;
        mode   = 2'b00;
        write_entry(4'd0, 1'b1, 3'd1, 32'd0, 32'd3);
        swap_idle("swap_idle_c");
        write_entry(4'd0, 1'b1, 3'd1, 32'd0, 32'd6);
        period       = 32'sd10;
        outer_period = 32'sd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("swaprun_k0", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            cfg_if.cfg_swap = (k == 2);
            tick();
            c  = (k - 1) % 10;
            st = (c >= ((k <= 20) ? 3 : 6)) ? 8'h02 : 8'h00;
            expect_out($sformatf("swaprun_k%0d", k), st, 8'hFF, 1'b1, 1'b0, (k == 20));
        end
        cfg_if.cfg_swap = 1'b0;
        stop_run("swaprun_stop");

        // 6 triggered one-shot, then stop beats trig in ARMED
        state0       = 8'h3C;
        mode         = 2'b10;
        period       = 32'sd3;
        outer_period = 32'sd1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("armed0", 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("armed1", 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        expect_out("trig_run", 8'h3C, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            expect_out($sformatf("trig_k%0d", k), 8'h3C, 8'hFF, (k < 3), (k == 3), 1'b0);
        end
        trig = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("stop_vs_trig", 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        trig = 1'b0;
        expect_out("idle_ignores_trig", 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);

        // 7 non-positive periods act as 1
        state0       = 8'h00;
        mode         = 2'b01;
        period       = 32'sd0;
        outer_period = -32'sd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("p0_run", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("p0_done", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("p0_idle", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

        // 8 reset mid-run discards a pending swap
        state0       = 8'h0F;
        mode         = 2'b00;
        period       = 32'sd10;
        outer_period = 32'sd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_out("rst_run", 8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0);
        cfg_if.cfg_swap = 1'b1;
        tick();
        cfg_if.cfg_swap = 1'b0;
        expect_out("rst_pending", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        expect_out("rst_mid", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        expect_out("rst_idle0", 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rst_idle1", 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
